// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Groups the byte-stream input, the imem write port and the status flags of
// the boot program loader into one bundle.
//
// Handshake: a byte transfers on every rising clk edge where
// rx_valid && rx_ready is high. The producer holds rx_data stable while
// rx_valid is high. The loader keeps rx_ready high in every state, so every
// valid byte is consumed in the cycle it is offered.
//
// Signals
//   rx_data    [7:0]         byte from the UART receiver
//   rx_valid                 rx_data is valid
//   rx_ready                 loader accepts a byte
//   imem_we                  imem write strobe, one cycle per word
//   imem_addr  [ADDR_W-1:0]  imem word address
//   imem_wdata [15:0]        instruction word {hi, lo}
//   cpu_hold                 1 = keep the CPU in reset
//   load_busy                frame in progress
//   load_done                last frame loaded successfully
//   load_err                 last frame failed
//   dbg_state  [2:0]         current loader FSM state (debug only)
//
// Modports
//   master : the loader (drives rx_ready, imem port and status)
//   slave  : the environment (UART side drives rx_*, observes the rest)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [2:0]        dbg_state;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_hold,
        output load_busy,
        output load_done,
        output load_err,
        output dbg_state
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_hold,
        input  load_busy,
        input  load_done,
        input  load_err,
        input  dbg_state
    );
endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Boot-time program loader placed in front of the CPU instruction memory.
// Receives a framed byte stream:
//     SYNC_BYTE, LEN_H, LEN_L, 2*LEN payload bytes (hi byte first), CSUM
// where CSUM is the XOR of the payload bytes. Byte pairs are packed into
// 16-bit words and written to imem at consecutive addresses starting at 0.
// The CPU is held in reset until a frame with a matching checksum has been
// written completely.
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous, active-low reset
//   bus   : prog_loader_if.master (byte input, imem write port, status,
//           debug state)
//
// All outputs are registered. Words written by a frame that later fails
// stay in imem; only the status flags tell the failure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_H  = 3'd1,
        S_LEN_L  = 3'd2,
        S_DATA_H = 3'd3,
        S_DATA_L = 3'd4,
        S_CSUM   = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int unsigned     TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
    // Number of words imem can hold; 17 bits so ADDR_W up to 16 fits.
    localparam logic [16:0]     CAPACITY = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        csum_q, csum_d;
    // One bit wider than any legal length so it can reach len == 2^ADDR_W.
    logic [16:0]       wcnt_q, wcnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              rx_ready_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              fire;
    logic              in_frame;
    logic [15:0]       len_full;
    logic [16:0]       wcnt_inc;

    assign fire     = bus.rx_valid && rx_ready_q;
    assign in_frame = (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
                      (state_q == S_DATA_H) || (state_q == S_DATA_L) ||
                      (state_q == S_CSUM);
    assign len_full = {len_q[15:8], bus.rx_data};
    assign wcnt_inc = wcnt_q + 17'd1;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            hi_q       <= '0;
            csum_q     <= '0;
            wcnt_q     <= '0;
            to_q       <= '0;
            rx_ready_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            csum_q     <= csum_d;
            wcnt_q     <= wcnt_d;
            to_q       <= to_d;
            rx_ready_q <= 1'b1;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        wcnt_d  = wcnt_q;
        to_d    = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        // Inter-byte timer: only counts while a frame is open, and restarts
        // on every accepted byte.
        if (in_frame && !fire) begin
            to_d = to_q + TO_W'(1);
        end

        if (in_frame && (to_q == TO_LIMIT)) begin
            // Stalled stream wins over a byte arriving in the same cycle.
            state_d = S_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            hold_d  = 1'b1;
            to_d    = '0;
        end else if (fire) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    // Non-sync bytes between frames are dropped silently.
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_d = S_LEN_H;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        csum_d  = 8'h00;
                        busy_d  = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
                S_LEN_H: begin
                    len_d   = {bus.rx_data, len_q[7:0]};
                    state_d = S_LEN_L;
                end
                S_LEN_L: begin
                    len_d = len_full;
                    if ({1'b0, len_full} > CAPACITY) begin
                        state_d = S_ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA_H;
                        wcnt_d  = '0;
                    end
                end
                S_DATA_H: begin
                    hi_d    = bus.rx_data;
                    csum_d  = csum_q ^ bus.rx_data;
                    state_d = S_DATA_L;
                end
                S_DATA_L: begin
                    csum_d  = csum_q ^ bus.rx_data;
                    we_d    = 1'b1;
                    addr_d  = wcnt_q[ADDR_W-1:0];
                    wdata_d = {hi_q, bus.rx_data};
                    wcnt_d  = wcnt_inc;
                    state_d = (wcnt_inc == {1'b0, len_q}) ? S_CSUM : S_DATA_H;
                end
                S_CSUM: begin
                    if (bus.rx_data == csum_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_busy  = busy_q;
    assign bus.load_done  = done_q;
    assign bus.load_err   = err_q;
    assign bus.dbg_state  = state_q;

endmodule
